// File: rtl/alarm_pkg.sv
// Shared types for the alarm controller: state encoding and helpers.
// Optional tamper input is enabled with `define ALARM_TAMPER_EN.
package alarm_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_DISARMED = 3'd0,
    S_EXIT     = 3'd1,
    S_ARMED    = 3'd2,
    S_ENTRY    = 3'd3,
    S_ALARM    = 3'd4
  } state_e;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic is_armed(state_e s);
    return (s == S_ARMED) || (s == S_ENTRY) || (s == S_ALARM);
  endfunction

endpackage

// File: rtl/alarm_timer.sv
// Loadable down-counter shared by the exit, entry and siren timers.
// Holds at zero; load has priority over decrement.
module alarm_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/alarm_controller.sv
// N-zone home alarm: exit/entry delays, timed siren, latched trip memory.
// Define ALARM_TAMPER_EN to add the tamper_i input.
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int                NZONES     = 4,
  parameter logic [NZONES-1:0] ENTRY_MASK = 4'b0001,
  parameter int                EXIT_DLY   = 8,
  parameter int                ENTRY_DLY  = 8,
  parameter int                SIREN_CYC  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arm_i,
  input  logic [NZONES-1:0]  zone_i,
`ifdef ALARM_TAMPER_EN
  input  logic               tamper_i,
`endif
  output logic               alarm_o,
  output logic               armed_o,
  output logic [STATE_W-1:0] state_o,
  output logic [NZONES-1:0]  trip_o
);

  localparam int MAXD = max3(EXIT_DLY, ENTRY_DLY, SIREN_CYC);
  localparam int CW   = $clog2(MAXD) + 1;

  localparam logic [CW-1:0] EXIT_LD  = CW'(EXIT_DLY - 1);
  localparam logic [CW-1:0] ENTRY_LD = CW'(ENTRY_DLY - 1);
  localparam logic [CW-1:0] SIREN_LD = CW'(SIREN_CYC - 1);

  state_e            state_q, state_d;
  logic [NZONES-1:0] trip_q, trip_d;
  logic              load, en, zero, clr_trip;
  logic [CW-1:0]     load_val;
  logic              tamper, inst_hit, ent_hit;

`ifdef ALARM_TAMPER_EN
  assign tamper = tamper_i;
`else
  assign tamper = 1'b0;
`endif

  assign inst_hit = |(zone_i & ~ENTRY_MASK);
  assign ent_hit  = |(zone_i & ENTRY_MASK);

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_val = '0;
    en       = 1'b0;
    clr_trip = 1'b0;
    unique case (state_q)
      S_DISARMED: begin
        // tamper beats a low arm switch only here
        if (tamper) begin
          state_d  = S_ALARM;
          load     = 1'b1;
          load_val = SIREN_LD;
        end else if (arm_i) begin
          state_d  = S_EXIT;
          load     = 1'b1;
          load_val = EXIT_LD;
          clr_trip = 1'b1;
        end
      end
      S_EXIT: begin
        if (!arm_i) begin
          state_d = S_DISARMED;
        end else if (tamper) begin
          state_d  = S_ALARM;
          load     = 1'b1;
          load_val = SIREN_LD;
        end else if (zero) begin
          state_d = S_ARMED;
        end else begin
          en = 1'b1;
        end
      end
      S_ARMED: begin
        if (!arm_i) begin
          state_d = S_DISARMED;
        end else if (tamper || inst_hit) begin
          state_d  = S_ALARM;
          load     = 1'b1;
          load_val = SIREN_LD;
        end else if (ent_hit) begin
          state_d  = S_ENTRY;
          load     = 1'b1;
          load_val = ENTRY_LD;
        end
      end
      S_ENTRY: begin
        if (!arm_i) begin
          state_d = S_DISARMED;
        end else if (tamper || inst_hit || zero) begin
          state_d  = S_ALARM;
          load     = 1'b1;
          load_val = SIREN_LD;
        end else begin
          en = 1'b1;
        end
      end
      S_ALARM: begin
        if (!arm_i) begin
          state_d = S_DISARMED;
        end else if (zero) begin
          state_d = S_ARMED;
        end else begin
          en = 1'b1;
        end
      end
      default: state_d = S_DISARMED;
    endcase
  end

  always_comb begin
    trip_d = trip_q;
    if (clr_trip) begin
      trip_d = '0;
    end else if (is_armed(state_q)) begin
      trip_d = trip_q | zone_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_DISARMED;
      trip_q  <= '0;
    end else begin
      state_q <= state_d;
      trip_q  <= trip_d;
    end
  end

  alarm_timer #(
    .W(CW)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load),
    .load_val_i(load_val),
    .en_i      (en),
    .zero_o    (zero)
  );

  assign state_o = state_q;
  assign alarm_o = (state_q == S_ALARM);
  assign armed_o = is_armed(state_q);
  assign trip_o  = trip_q;

endmodule
